// File: rtl/busy_table.sv
// Physical-register busy scoreboard: one busy bit per register plus a registered busy count.
// Define QU_BUSY_TABLE_BYPASS_EN to let same-cycle set/clear writes show on the read ports.
module busy_table #(
    parameter  int PHY_RF_DEPTH      = 128,
    localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] set_addr,
    input  logic                         set_data,
    input  logic                         clr_en,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] clr_addr,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] rd_addr1,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] rd_addr2,
    output logic                         rd_busy1,
    output logic                         rd_busy2,
    output logic [PHY_RF_ADDR_WIDTH:0]   num_busy
);

    logic [PHY_RF_DEPTH-1:0]    busy_q, busy_d;
    logic [PHY_RF_ADDR_WIDTH:0] num_busy_q, num_busy_d;

    logic set_hit, clr_hit, clr_eff;
    logic inc_set, dec_set, dec_clr;

    // Register 0 is hardwired ready, so writes aimed at it never take effect.
    assign set_hit = set_en && (set_addr != '0);
    assign clr_hit = clr_en && (clr_addr != '0);
    assign clr_eff = clr_hit && !(set_hit && (set_addr == clr_addr));

    // Count only real bit transitions so the counter tracks the popcount exactly.
    assign inc_set = set_hit &&  set_data && !busy_q[set_addr];
    assign dec_set = set_hit && !set_data &&  busy_q[set_addr];
    assign dec_clr = clr_eff && busy_q[clr_addr];

    always_comb begin
        busy_d = busy_q;
        if (clr_hit) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_hit) begin
            busy_d[set_addr] = set_data;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        num_busy_d = num_busy_q
                   + {{PHY_RF_ADDR_WIDTH{1'b0}}, inc_set}
                   - {{PHY_RF_ADDR_WIDTH{1'b0}}, dec_set}
                   - {{PHY_RF_ADDR_WIDTH{1'b0}}, dec_clr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            num_busy_q <= '0;
        end else begin
            busy_q     <= busy_d;
            num_busy_q <= num_busy_d;
        end
    end

    assign num_busy = num_busy_q;

`ifdef QU_BUSY_TABLE_BYPASS_EN
    // Same-cycle writes forward to the read ports; set beats clear on a collision.
    always_comb begin
        rd_busy1 = busy_q[rd_addr1];
        if (set_hit && (set_addr == rd_addr1)) begin
            rd_busy1 = set_data;
        end else if (clr_hit && (clr_addr == rd_addr1)) begin
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_busy2 = busy_q[rd_addr2];
        if (set_hit && (set_addr == rd_addr2)) begin
            rd_busy2 = set_data;
        end else if (clr_hit && (clr_addr == rd_addr2)) begin
            rd_busy2 = 1'b0;
        end
    end
`else
    assign rd_busy1 = busy_q[rd_addr1];
    assign rd_busy2 = busy_q[rd_addr2];
`endif

endmodule

// File: tb/tb_busy_table.sv
// Bench for busy_table: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an array-based model of the busy state.
module tb_busy_table;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst, set_en, set_data, clr_en;
    logic [AW-1:0] set_addr, clr_addr, rd_addr1, rd_addr2;
    logic          rd_busy1, rd_busy2;
    logic [AW:0]   num_busy;

    bit model[DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    busy_table #(.PHY_RF_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (set_addr),
        .set_data (set_data),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .num_busy (num_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += model[i];
        return n;
    endfunction

    function automatic bit exp_rd(input logic [AW-1:0] a);
        bit v = model[a];
`ifdef QU_BUSY_TABLE_BYPASS_EN
        if (a != 0) begin
            if (set_en && set_addr == a)      v = set_data;
            else if (clr_en && clr_addr == a) v = 1'b0;
        end
`endif
        return v;
    endfunction

    task automatic update_model();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 1'b0;
        end else begin
            if (clr_en && clr_addr != 0) model[clr_addr] = 1'b0;
            if (set_en && set_addr != 0) model[set_addr] = set_data;
        end
    endtask

    task automatic drive(input bit r, input bit se, input int sa, input bit sd,
                         input bit ce, input int ca, input int r1, input int r2);
        rst = r; set_en = se; set_addr = AW'(sa); set_data = sd;
        clr_en = ce; clr_addr = AW'(ca); rd_addr1 = AW'(r1); rd_addr2 = AW'(r2);
    endtask

    task automatic sample();
        @(negedge clk);
        check("rd_busy1", rd_busy1, exp_rd(rd_addr1));
        check("rd_busy2", rd_busy2, exp_rd(rd_addr2));
        check("num_busy", num_busy, popcount());
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        drive(1, 1, 3, 1, 0, 0, 0, 0);
        advance();

        // Reset then read
        drive(0, 0, 0, 0, 0, 0, 5, 127);
        sample();
        check("rst_rd1", rd_busy1, 0);
        check("rst_rd2", rd_busy2, 0);
        check("rst_num", num_busy, 0);
        advance();

        // Set then clear register 7
        drive(0, 1, 7, 1, 0, 0, 7, 7); cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        sample();
        check("set7_rd", rd_busy1, 1);
        check("set7_num", num_busy, 1);
        advance();
        drive(0, 0, 0, 0, 1, 7, 7, 7); cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        sample();
        check("clr7_rd", rd_busy1, 0);
        check("clr7_num", num_busy, 0);
        advance();

        // Collision: set wins
        drive(0, 1, 9, 1, 0, 0, 9, 12); cycle();
        drive(0, 1, 12, 1, 1, 12, 9, 12); cycle();
        drive(0, 1, 9, 1, 0, 0, 12, 9);
        sample();
        check("coll_rd12", rd_busy1, 1);
        check("coll_num", num_busy, 2);
        advance();
        drive(0, 0, 0, 0, 0, 0, 12, 9);
        sample();
        check("reset9_num", num_busy, 2);
        advance();

        // Address 0 is never busy
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        sample();
        check("addr0_rd", rd_busy1, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 9);
        sample();
        check("addr0_rd_after", rd_busy1, 0);
        check("addr0_num", num_busy, 2);
        advance();

        // Same-cycle clear visibility
        drive(0, 1, 20, 1, 0, 0, 20, 20); cycle();
        drive(0, 0, 0, 0, 1, 20, 20, 9);
        sample();
`ifdef QU_BUSY_TABLE_BYPASS_EN
        check("bypass_rd20", rd_busy1, 0);
`else
        check("bypass_rd20", rd_busy1, 1);
`endif
        advance();

        // Reset mid-operation discards in-flight set
        drive(0, 1, 3, 1, 0, 0, 3, 4); cycle();
        drive(0, 1, 4, 1, 0, 0, 3, 4); cycle();
        drive(1, 1, 5, 1, 1, 3, 3, 5); advance();
        drive(0, 0, 0, 0, 0, 0, 3, 5);
        sample();
        check("mid_rst_rd3", rd_busy1, 0);
        check("mid_rst_rd5", rd_busy2, 0);
        check("mid_rst_num", num_busy, 0);
        advance();

        // Fill every register, then drain two per cycle
        for (int a = 1; a < DEPTH; a++) begin
            drive(0, 1, a, 1, 0, 0, a, a - 1); cycle();
        end
        drive(0, 1, 5, 1, 1, 0, 127, 0);
        sample();
        check("full_num", num_busy, DEPTH - 1);
        advance();
        for (int a = 1; a < 64; a++) begin
            drive(0, 1, a + 64, 0, 1, a, a, a + 64); cycle();
        end
        drive(0, 0, 0, 0, 1, 64, 64, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 64, 127);
        sample();
        check("drained_num", num_busy, 0);
        advance();

        // Randomized traffic, biased toward a small address window for collisions
        for (int n = 0; n < 3000; n++) begin
            int win;
            win = ($urandom_range(0, 1) == 0) ? 15 : DEPTH - 1;
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, win), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, win),
                  $urandom_range(0, win), $urandom_range(0, win));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
